nios2_bus_input: RTL and testbench
==================================

# nios2_bus_input

Avalon-MM input PIO slave for the Nios II system: the CPU-facing receiver for external 8-bit signals, the opposite direction to the bus output PIO. Samples `in_port` through a synchronizer, exposes its current value, and latches selected edges into a sticky edge-capture register. It raises a level interrupt when a captured edge is unmasked. Sits on the same Avalon data bus as the output PIO, with the same 2-bit word address and 32-bit data path.

## Interface
Parameters:
- `WIDTH`, 8, width of `in_port` and of every internal register.
- `SYNC_STAGES`, 2, synchronizer flops on `in_port`; legal values 2..4.
- `EDGE_TYPE`, 0, edges captured: 0 = rising, 1 = falling, 2 = any.
- `IRQ_RESET_MASK`, 0, reset value of the interrupt mask register.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write is `chipselect && !write_n`.
- `writedata`  in  32  write data; only `[WIDTH-1:0]` is used.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `readdata`  out  32  registered read data, zero-extended above `WIDTH`.
- `irq`  out  1  level interrupt to the CPU.

## Operation
Register map:
- Address 0, DATA: read-only; returns the synchronized `in_port`. Writes are ignored.
- Address 1: reserved; reads 0, writes ignored.
- Address 2, IRQMASK: read/write, `WIDTH` bits.
- Address 3, EDGECAP: read; a write of 1 to a bit clears that bit, and a write of 0 leaves it unchanged.

Synchronizer and edge detection:
- `sync` is the final synchronizer stage. `prev` is `sync` delayed by one clock.
- Per bit, `edge[i]` is:
  - `sync & ~prev` when `EDGE_TYPE` = 0,
  - `~sync & prev` when `EDGE_TYPE` = 1,
  - `sync ^ prev` when `EDGE_TYPE` = 2.
- Per bit, on each clock, `EDGECAP[i] <= edge[i] | (EDGECAP[i] & ~clr[i])`. `clr[i]` is `writedata[i]` during a write to address 3, and 0 otherwise.
- A new edge and a clear on the same bit in the same cycle: the edge wins, so the bit stays 1.
- `irq = |(EDGECAP & IRQMASK)`. It is combinational from registers and has no extra latency.
- Reserved values of `EDGE_TYPE` or `SYNC_STAGES` are rejected by an elaboration-time check.

## Timing
- Reset, asynchronous: synchronizer, `prev`, `EDGECAP` and `readdata` clear to 0. `IRQMASK` loads `IRQ_RESET_MASK`. `irq` is therefore 0.
- Reset mid-operation clears all captured edges. `prev` resets to 0, so an input held high through reset produces one rising edge capture after release, at normal latency.
- Input latency: a change on `in_port` that is stable before clock edge k appears in `sync` after edge k+`SYNC_STAGES`-1.
  - `EDGECAP` sets after edge k+`SYNC_STAGES`.
  - `irq` rises in the same cycle as `EDGECAP`.
- Read latency is 1 cycle. `readdata` is registered every clock from the address mux, gated by `chipselect`, and is 0 when not selected. Data for an address presented in cycle c is valid after the next edge.
- A write takes effect at the clock edge that samples it. A read of the same register in the following cycle returns the new value.
- Input pulses shorter than one clock period may be missed; this is not guaranteed behaviour.

## Structure
- Package `nios2_pio_pkg`:
  - address constants `PIO_ADDR_DATA`, `PIO_ADDR_IRQMASK`, `PIO_ADDR_EDGECAP`;
  - edge-type constants `PIO_EDGE_RISE`, `PIO_EDGE_FALL`, `PIO_EDGE_ANY`.
  - The output PIO imports the same package.
- Sub-module `nios2_pio_sync`: a parameterized `WIDTH` x `SYNC_STAGES` flop chain with asynchronous reset. It is reused by any future input-side block.

## Test plan
- Reset: assert `reset_n`=0 mid-traffic with `IRQ_RESET_MASK`=0 -> `readdata`=0, `irq`=0, EDGECAP reads 0, IRQMASK reads 0x00.
- Data path: drive `in_port`=0xA5 and wait 3 clocks, then read address 0 -> `readdata`=0x000000A5 one cycle after the read. A write of 0xFF to address 0 has no effect.
- Rising capture: `EDGE_TYPE`=0, IRQMASK=0x01, `in_port` 0x00->0x03 -> EDGECAP=0x03 and `irq`=1 exactly `SYNC_STAGES`+1 edges after the change. A later `in_port`->0x00 leaves EDGECAP=0x03.
- Clear: write 0x01 to address 3 -> EDGECAP=0x02 and `irq`=0. Write 0x02 -> EDGECAP=0x00.
- Simultaneous set/clear: time a write of 0x04 to address 3 into the cycle in which bit 2 sees a new edge -> EDGECAP bit 2 = 1.
- Any-edge mode: `EDGE_TYPE`=2, toggle bit 7 twice with 4 clocks between toggles, clearing in between -> the bit is captured on both toggles. `irq` follows IRQMASK bit 7 set/clear immediately.

Source files
------------

// File: rtl/nios2_pio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios2_pio_pkg: register map and edge-type constants for the PIOs   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package nios2_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/nios2_bus_input_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios2_bus_input_if: Avalon-MM slave bus plus level interrupt       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface nios2_bus_input_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface
`default_nettype wire

// File: rtl/nios2_pio_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios2_pio_sync: WIDTH x STAGES synchronizer chain, async reset     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nios2_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/nios2_bus_input.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios2_bus_input: Avalon-MM input PIO with edge capture and IRQ     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nios2_bus_input
  import nios2_pio_pkg::*;
#(
  parameter int          WIDTH          = 8,
  parameter int          SYNC_STAGES    = 2,
  parameter int          EDGE_TYPE      = 0,
  parameter int unsigned IRQ_RESET_MASK = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  nios2_bus_input_if.slave bus
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $fatal(1, "nios2_bus_input: SYNC_STAGES must be 2..4");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "nios2_bus_input: WIDTH must be 1..32");
  end

  nios2_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_q)
  );

  if (EDGE_TYPE == PIO_EDGE_RISE) begin : g_rise
    assign edge_det = sync_q & ~prev;
  end else if (EDGE_TYPE == PIO_EDGE_FALL) begin : g_fall
    assign edge_det = ~sync_q & prev;
  end else if (EDGE_TYPE == PIO_EDGE_ANY) begin : g_any
    assign edge_det = sync_q ^ prev;
  end else begin : g_bad_edge_type
    $fatal(1, "nios2_bus_input: EDGE_TYPE must be 0..2");
  end

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign clr          = (wr_en && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rd_mux = 32'(sync_q);
      PIO_ADDR_RSVD:    rd_mux = '0;
      PIO_ADDR_IRQMASK: rd_mux = 32'(irq_mask);
      PIO_ADDR_EDGECAP: rd_mux = 32'(edge_cap);
      default:          rd_mux = '0;
    endcase
  end

  // A fresh edge takes priority over a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      edge_cap     <= '0;
      irq_mask     <= WIDTH'(IRQ_RESET_MASK);
      bus.readdata <= '0;
    end else begin
      prev         <= sync_q;
      edge_cap     <= edge_det | (edge_cap & ~clr);
      bus.readdata <= bus.chipselect ? rd_mux : 32'd0;
      if (wr_en && bus.address == PIO_ADDR_IRQMASK) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  assign bus.irq = |(edge_cap & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios2_bus_input.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nios2_bus_input: scoreboard bench, rising and any-edge DUTs     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_nios2_bus_input;
  import nios2_pio_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_port = 8'h00;

  nios2_bus_input_if bus_rise ();
  nios2_bus_input_if bus_any ();

  assign bus_any.address    = bus_rise.address;
  assign bus_any.chipselect = bus_rise.chipselect;
  assign bus_any.write_n    = bus_rise.write_n;
  assign bus_any.writedata  = bus_rise.writedata;

  nios2_bus_input #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(PIO_EDGE_RISE),
                    .IRQ_RESET_MASK(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus_rise));

  nios2_bus_input #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(PIO_EDGE_ANY),
                    .IRQ_RESET_MASK(0)) dut_any (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus_any));

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sync is in_port as sampled SYNC_STAGES-1 edges ago (zero
  // until that many post-reset edges exist); index 0 = rising, 1 = any-edge.
  logic [7:0]  hist [16];
  int          since;
  logic [7:0]  m_sync, m_prev;
  logic [7:0]  m_cap  [2];
  logic [7:0]  m_mask [2];
  logic        m_irq  [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  function automatic logic [7:0] edges(input int mode, input logic [7:0] s, input logic [7:0] p);
    if (mode == 0) return s & ~p;
    return s ^ p;
  endfunction

  always @(posedge clk) begin
    logic [7:0]  s_pre, p_pre, clr;
    logic [31:0] rd;
    if (!reset_n) begin
      since  = 0;
      m_sync = 8'h00;
      m_prev = 8'h00;
      for (int m = 0; m < 2; m++) begin
        m_cap[m]  = 8'h00;
        m_mask[m] = 8'h00;
        m_irq[m]  = 1'b0;
      end
    end else begin
      s_pre = m_sync;
      p_pre = m_prev;
      clr   = (bus_rise.chipselect && !bus_rise.write_n && bus_rise.address == 2'd3)
              ? bus_rise.writedata[7:0] : 8'h00;
      for (int m = 0; m < 2; m++) begin
        if (bus_rise.chipselect && bus_rise.write_n) begin
          case (bus_rise.address)
            2'd0:    rd = {24'h0, s_pre};
            2'd2:    rd = {24'h0, m_mask[m]};
            2'd3:    rd = {24'h0, m_cap[m]};
            default: rd = 32'h0;
          endcase
          if (m == 0) exp_q0.push_back(rd);
          else        exp_q1.push_back(rd);
        end
        m_cap[m] = edges(m, s_pre, p_pre) | (m_cap[m] & ~clr);
        if (bus_rise.chipselect && !bus_rise.write_n && bus_rise.address == 2'd2)
          m_mask[m] = bus_rise.writedata[7:0];
        m_irq[m] = |(m_cap[m] & m_mask[m]);
      end
      m_prev = s_pre;
      since++;
      hist[since % 16] = in_port;
      m_sync = (since >= SYNC_STAGES) ? hist[(since - SYNC_STAGES + 1) % 16] : 8'h00;
    end
  end

  // Monitor: a read seen at an edge is answered on readdata after that edge.
  logic was_read = 1'b0;
  always @(posedge clk) was_read = reset_n && bus_rise.chipselect && bus_rise.write_n;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_irq_rise", {31'h0, bus_rise.irq}, 32'h0);
      chk("rst_irq_any", {31'h0, bus_any.irq}, 32'h0);
      chk("rst_rdata_rise", bus_rise.readdata, 32'h0);
      chk("rst_rdata_any", bus_any.readdata, 32'h0);
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (was_read) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          chk("scoreboard_underflow", 32'(exp_q0.size() + exp_q1.size()), 32'd2);
        end else begin
          chk("read_rise", bus_rise.readdata, exp_q0.pop_front());
          chk("read_any", bus_any.readdata, exp_q1.pop_front());
        end
      end
      chk("irq_rise", {31'h0, bus_rise.irq}, {31'h0, m_irq[0]});
      chk("irq_any", {31'h0, bus_any.irq}, {31'h0, m_irq[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus_rise.chipselect = 1'b0;
    bus_rise.write_n    = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_rise.chipselect = 1'b1;
    bus_rise.write_n    = 1'b0;
    bus_rise.address    = a;
    bus_rise.writedata  = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [1:0] a);
    bus_rise.chipselect = 1'b1;
    bus_rise.write_n    = 1'b1;
    bus_rise.address    = a;
    tick();
    idle();
  endtask

  initial begin
    bus_rise.address   = 2'd0;
    bus_rise.writedata = 32'h0;
    idle();
    repeat (3) tick();
    reset_n = 1'b1;

    rd(PIO_ADDR_IRQMASK);  chk("reset_mask", bus_rise.readdata, 32'h0);
    rd(PIO_ADDR_EDGECAP);  chk("reset_cap", bus_rise.readdata, 32'h0);

    in_port = 8'hA5;
    repeat (3) tick();
    rd(PIO_ADDR_DATA);     chk("data_a5", bus_rise.readdata, 32'h0000_00A5);
    wr(PIO_ADDR_DATA, 32'hFF);
    rd(PIO_ADDR_DATA);     chk("data_ro", bus_rise.readdata, 32'h0000_00A5);

    wr(PIO_ADDR_IRQMASK, 32'h01);
    in_port = 8'h00;
    repeat (3) tick();
    wr(PIO_ADDR_EDGECAP, 32'hFF);
    chk("pre_irq", {31'h0, bus_rise.irq}, 32'h0);
    in_port = 8'h03;
    tick(); tick();
    chk("irq_not_early", {31'h0, bus_rise.irq}, 32'h0);
    tick();
    chk("irq_latency", {31'h0, bus_rise.irq}, 32'h1);
    rd(PIO_ADDR_EDGECAP);  chk("cap_rise", bus_rise.readdata, 32'h03);
    in_port = 8'h00;
    repeat (3) tick();
    rd(PIO_ADDR_EDGECAP);  chk("cap_sticky", bus_rise.readdata, 32'h03);

    wr(PIO_ADDR_EDGECAP, 32'h01);
    chk("clr_irq", {31'h0, bus_rise.irq}, 32'h0);
    rd(PIO_ADDR_EDGECAP);  chk("clr_bit0", bus_rise.readdata, 32'h02);
    wr(PIO_ADDR_EDGECAP, 32'h02);
    rd(PIO_ADDR_EDGECAP);  chk("clr_bit1", bus_rise.readdata, 32'h00);

    in_port = 8'h04;
    tick(); tick();
    wr(PIO_ADDR_EDGECAP, 32'h04);
    rd(PIO_ADDR_EDGECAP);  chk("set_wins", bus_rise.readdata, 32'h04);

    repeat (3) tick();
    wr(PIO_ADDR_IRQMASK, 32'h80);
    wr(PIO_ADDR_EDGECAP, 32'hFF);
    in_port = 8'h84;
    repeat (4) tick();
    rd(PIO_ADDR_EDGECAP);  chk("any_toggle1", bus_any.readdata, 32'h80);
    wr(PIO_ADDR_EDGECAP, 32'h80);
    chk("any_clr_irq", {31'h0, bus_any.irq}, 32'h0);
    in_port = 8'h04;
    repeat (4) tick();
    chk("any_toggle2_irq", {31'h0, bus_any.irq}, 32'h1);
    rd(PIO_ADDR_EDGECAP);  chk("any_toggle2", bus_any.readdata, 32'h80);
    wr(PIO_ADDR_IRQMASK, 32'h00);
    chk("mask_off_irq", {31'h0, bus_any.irq}, 32'h0);
    wr(PIO_ADDR_IRQMASK, 32'h80);
    chk("mask_on_irq", {31'h0, bus_any.irq}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        in_port = 8'hFF;
        repeat (3) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
      end
      bus_rise.chipselect = 1'($urandom_range(0, 1));
      bus_rise.write_n    = ($urandom_range(0, 3) != 0);
      bus_rise.address    = 2'($urandom_range(0, 3));
      bus_rise.writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom);
      tick();
    end
    idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
